// File: rtl/simplerisc_pkg.sv
// Shared constants for the SimpleRISC sequencer: opcodes, decoder flag positions,
// FSM state encoding and the PC / register-file write-data select codes.
package simplerisc_pkg;

  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_LD  = 5'b01110;
  localparam logic [4:0] OP_ST  = 5'b01111;

  // Bit positions inside dec_flags = {ret,call,ubranch,bgt,beq,st,ld,wb}
  localparam int DF_WB   = 0;
  localparam int DF_LD   = 1;
  localparam int DF_ST   = 2;
  localparam int DF_BEQ  = 3;
  localparam int DF_BGT  = 4;
  localparam int DF_UBR  = 5;
  localparam int DF_CALL = 6;
  localparam int DF_RET  = 7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_RA     = 2'd2;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/simplerisc_branch_resolve.sv
// Combinational PC-select: ret beats everything, then any taken branch or call.
module simplerisc_branch_resolve
  import simplerisc_pkg::*;
(
  input  logic       is_ret,
  input  logic       is_call,
  input  logic       is_ubranch,
  input  logic       is_beq,
  input  logic       is_bgt,
  input  logic       flag_e,
  input  logic       flag_gt,
  output logic [1:0] pc_sel
);

  always_comb begin
    pc_sel = PC_SEL_NEXT;
    if (is_ret)
      pc_sel = PC_SEL_RA;
    else if (is_ubranch | is_call | (is_beq & flag_e) | (is_bgt & flag_gt))
      pc_sel = PC_SEL_BRANCH;
  end

endmodule

// File: rtl/simplerisc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with cmp flags and mul/div timeout.
// Optional SEQ_PERF_CNT_EN adds cycle and retire counters (cyc_cnt, ret_cnt).
module simplerisc_seq_ctrl
  import simplerisc_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic [4:0]  opcode,
  input  logic [7:0]  dec_flags,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        alu_eq,
  input  logic        alu_gt,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        flag_e,
  output logic        flag_gt,
  output logic        retire
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam int CNT_W = (MULDIV_TIMEOUT > 0) ? $clog2(MULDIV_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MULDIV_TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             muldiv;
  logic             timed_out;
  logic             exec_done;
  logic             mem_op;
  logic [1:0]       br_sel;

  assign muldiv    = is_muldiv(opcode);
  // wait_cnt counts completed EXEC cycles, so the last permitted cycle is MAX-1
  assign timed_out = (MULDIV_TIMEOUT != 0) && (wait_cnt == CNT_MAX - 1'b1);
  assign exec_done = !muldiv || alu_done || timed_out;
  assign mem_op    = dec_flags[DF_LD] | dec_flags[DF_ST];

  simplerisc_branch_resolve u_branch (
    .is_ret     (dec_flags[DF_RET]),
    .is_call    (dec_flags[DF_CALL]),
    .is_ubranch (dec_flags[DF_UBR]),
    .is_beq     (dec_flags[DF_BEQ]),
    .is_bgt     (dec_flags[DF_BGT]),
    .flag_e     (flag_e),
    .flag_gt    (flag_gt),
    .pc_sel     (br_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   if (exec_done) state_next = mem_op ? ST_MEM : ST_WB;
      ST_MEM:    if (dmem_ack) state_next = ST_WB;
      ST_WB:     state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Outputs are forced idle while rst is held so requests drop on the reset edge
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_NEXT;
    retire   = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_flags[DF_ST];
        end
        ST_WB: begin
          rf_we  = dec_flags[DF_WB] | dec_flags[DF_LD] | dec_flags[DF_CALL];
          if (dec_flags[DF_LD])        rf_wsel = WSEL_MEM;
          else if (dec_flags[DF_CALL]) rf_wsel = WSEL_LINK;
          pc_we  = 1'b1;
          pc_sel = br_sel;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_start <= 1'b0;
      flag_e    <= 1'b0;
      flag_gt   <= 1'b0;
    end else begin
      alu_start <= (state == ST_DECODE);
      if (state == ST_EXEC && exec_done && opcode == OP_CMP) begin
        flag_e  <= alu_eq;
        flag_gt <= alu_gt;
      end
    end
  end

  // Held at zero outside EXEC, so it is clear on every EXEC entry; saturates
  always_ff @(posedge clk) begin
    if (rst || state != ST_EXEC)
      wait_cnt <= '0;
    else if (wait_cnt != CNT_MAX)
      wait_cnt <= wait_cnt + 1'b1;
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simplerisc_seq_ctrl.sv
// Scoreboard bench for simplerisc_seq_ctrl (MULDIV_TIMEOUT=4); checks counters when SEQ_PERF_CNT_EN.
module tb_simplerisc_seq_ctrl;

  localparam int TIMEOUT = 4;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_LDI = 5'b01110;
  localparam logic [4:0] OP_STI = 5'b01111;
  localparam logic [4:0] OP_BR  = 5'b10000;

  localparam logic [7:0] F_WB   = 8'h01;
  localparam logic [7:0] F_LD   = 8'h02;
  localparam logic [7:0] F_ST   = 8'h04;
  localparam logic [7:0] F_BEQ  = 8'h08;
  localparam logic [7:0] F_BGT  = 8'h10;
  localparam logic [7:0] F_UBR  = 8'h20;
  localparam logic [7:0] F_CALL = 8'h40;
  localparam logic [7:0] F_RET  = 8'h80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_ack = 1'b0;
  logic [4:0] opcode = '0;
  logic [7:0] dec_flags = '0;
  logic       alu_done = 1'b0;
  logic       alu_eq = 1'b0;
  logic       alu_gt = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, ir_we, alu_start, dmem_req, dmem_we, rf_we, pc_we;
  logic       flag_e, flag_gt, retire;
  logic [1:0] rf_wsel, pc_sel;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  simplerisc_seq_ctrl #(.MULDIV_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .opcode(opcode), .dec_flags(dec_flags),
    .alu_start(alu_start), .alu_done(alu_done), .alu_eq(alu_eq), .alu_gt(alu_gt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .pc_we(pc_we), .pc_sel(pc_sel),
    .flag_e(flag_e), .flag_gt(flag_gt), .retire(retire)
`ifdef SEQ_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [1:0] pc_sel;
    int         retire_idx;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   retired = 0;
  logic m_e = 1'b0;
  logic m_gt = 1'b0;

  // Drives one instruction through the sequencer and checks it at retirement.
  // done_dly < 0 means alu_done never arrives; junk drives acks/done when not expected.
  task automatic run_instr(input string name, input logic [4:0] op, input logic [7:0] fl,
                           input int fetch_dly, input int done_dly, input int mem_dly,
                           input logic eq, input logic gt, input logic junk);
    exp_t e;
    exp_t got;
    int   exec_len, mem_len;
    int   fetch_wait, mem_wait, ack_idx, start_idx, start_cnt, dmem_cnt, ret_idx;
    bit   in_exec, done, bad_we, bad_ir;
    exec_len = 1;
    if (op == OP_MUL || op == OP_DIV || op == OP_MOD)
      exec_len = (done_dly >= 0 && done_dly < TIMEOUT) ? done_dly + 1 : TIMEOUT;
    mem_len = (fl[1] | fl[2]) ? mem_dly + 1 : 0;
    e.retire_idx = 2 + exec_len + mem_len;
    e.rf_we      = fl[0] | fl[1] | fl[6];
    e.rf_wsel    = fl[1] ? 2'd1 : (fl[6] ? 2'd2 : 2'd0);
    if (fl[7])                                                  e.pc_sel = 2'd2;
    else if (fl[5] | fl[6] | (fl[3] & m_e) | (fl[4] & m_gt))    e.pc_sel = 2'd1;
    else                                                        e.pc_sel = 2'd0;
    sb.push_back(e);
    if (op == OP_CMP) begin
      m_e  = eq;
      m_gt = gt;
    end
    opcode = op; dec_flags = fl; alu_eq = eq; alu_gt = gt;
    fetch_wait = 0; mem_wait = 0; ack_idx = -1; start_idx = -1; start_cnt = 0;
    dmem_cnt = 0; ret_idx = -1; in_exec = 0; done = 0; bad_we = 0; bad_ir = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (alu_start) begin
        start_cnt++;
        start_idx = n;
        in_exec = 1;
      end
      if (dmem_req || retire) in_exec = 0;
      if (dmem_req) begin
        dmem_cnt++;
        if (dmem_we !== fl[2]) bad_we = 1;
      end
      if (retire) begin
        done = 1;
        ret_idx = n - ack_idx;
        retired++;
        got.rf_we = rf_we; got.rf_wsel = rf_wsel; got.pc_sel = pc_sel;
        tests_run++;
        if (pc_we !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s pc_we: got %0b, expected 1", name, pc_we);
        end
        tests_run++;
        if (flag_e !== m_e || flag_gt !== m_gt) begin
          tests_failed++;
          $display("[TB] FAIL %s flags: got e=%0b gt=%0b, expected e=%0b gt=%0b", name, flag_e, flag_gt, m_e, m_gt);
        end
      end
      imem_ack = imem_req ? (fetch_wait == fetch_dly) : junk;
      if (imem_req) begin
        if (imem_ack) ack_idx = n;
        fetch_wait++;
      end
      dmem_ack = dmem_req ? (mem_wait == mem_dly) : junk;
      if (dmem_req) mem_wait++;
      alu_done = in_exec ? ((n - start_idx) == done_dly) : junk;
      #1;
      if (ir_we !== (imem_req & imem_ack)) bad_ir = 1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; alu_done = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL %s retire timeout: got none, expected within 300 cycles", name);
      void'(sb.pop_front());
      return;
    end
    got.retire_idx = ret_idx;
    e = sb.pop_front();
    tests_run++;
    if (got.retire_idx != e.retire_idx) begin
      tests_failed++;
      $display("[TB] FAIL %s retire cycle: got %0d, expected %0d", name, got.retire_idx, e.retire_idx);
    end
    tests_run++;
    if (got.rf_we !== e.rf_we || got.rf_wsel !== e.rf_wsel) begin
      tests_failed++;
      $display("[TB] FAIL %s rf write: got we=%0b wsel=%0d, expected we=%0b wsel=%0d", name, got.rf_we, got.rf_wsel, e.rf_we, e.rf_wsel);
    end
    tests_run++;
    if (got.pc_sel !== e.pc_sel) begin
      tests_failed++;
      $display("[TB] FAIL %s pc_sel: got %0d, expected %0d", name, got.pc_sel, e.pc_sel);
    end
    tests_run++;
    if (start_cnt != 1 || start_idx - ack_idx != 2) begin
      tests_failed++;
      $display("[TB] FAIL %s alu_start: got %0d pulses at offset %0d, expected 1 at offset 2", name, start_cnt, start_idx - ack_idx);
    end
    tests_run++;
    if (dmem_cnt != mem_len || bad_we) begin
      tests_failed++;
      $display("[TB] FAIL %s dmem_req: got %0d cycles (we_err=%0b), expected %0d cycles", name, dmem_cnt, bad_we, mem_len);
    end
    tests_run++;
    if (bad_ir) begin
      tests_failed++;
      $display("[TB] FAIL %s ir_we: got mismatch with imem_ack, expected ir_we=imem_req&imem_ack", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({imem_req, dmem_req, alu_start, rf_we, pc_we, retire, ir_we} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset enables: got %b, expected 0000000", {imem_req, dmem_req, alu_start, rf_we, pc_we, retire, ir_we});
    end
    tests_run++;
    if ({flag_e, flag_gt, pc_sel, rf_wsel} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset flags/selects: got %b, expected 000000", {flag_e, flag_gt, pc_sel, rf_wsel});
    end
`ifdef SEQ_PERF_CNT_EN
    tests_run++;
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset counters: got %0d/%0d, expected 0/0", cyc_cnt, ret_cnt);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_alu();
    run_instr("add", OP_ADD, F_WB, 0, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cmp_branch();
    run_instr("cmp_eq", OP_CMP, 8'h00, 0, -1, 0, 1'b1, 1'b0, 1'b0);
    run_instr("beq_taken", OP_BR, F_BEQ, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("bgt_not_taken", OP_BR, F_BGT, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("cmp_gt", OP_CMP, 8'h00, 1, -1, 0, 1'b0, 1'b1, 1'b0);
    run_instr("beq_not_taken", OP_BR, F_BEQ, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("bgt_taken", OP_BR, F_BGT, 0, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_memory();
    run_instr("ld_wait3", OP_LDI, F_LD, 0, -1, 3, 1'b0, 1'b0, 1'b0);
    run_instr("st_junk", OP_STI, F_ST, 2, -1, 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_muldiv();
    run_instr("div_timeout", OP_DIV, F_WB, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("mul_done1", OP_MUL, F_WB, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("mod_done_at_timeout", OP_MOD, F_WB, 0, 3, 0, 1'b0, 1'b0, 1'b0);
    run_instr("mul_junk_done0", OP_MUL, F_WB, 1, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_call_ret();
    run_instr("call", OP_BR, F_CALL, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("ret", OP_BR, F_RET, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("ubranch", OP_BR, F_UBR, 0, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_instr("b2b", (i % 2 == 0) ? OP_ADD : OP_LDI, (i % 2 == 0) ? F_WB : F_LD,
                $urandom_range(0, 3), -1, $urandom_range(0, 2), 1'b0, 1'b0, i[0]);
`ifdef SEQ_PERF_CNT_EN
    tests_run++;
    if (ret_cnt !== 32'(retired)) begin
      tests_failed++;
      $display("[TB] FAIL ret_cnt: got %0d, expected %0d", ret_cnt, retired);
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    int  seen;
    bit  hit;
    run_instr("cmp_set_both", OP_CMP, 8'h00, 0, -1, 0, 1'b1, 1'b1, 1'b0);
    opcode = OP_LDI; dec_flags = F_LD; seen = 0; hit = 0;
    for (int n = 0; n < 30 && !hit; n++) begin
      @(negedge clk);
      if (dmem_req) seen++;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      if (seen == 2) begin
        rst = 1'b1;
        hit = 1;
      end
    end
    imem_ack = 1'b0;
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset reach MEM: got %0d dmem_req cycles, expected 2", seen);
    end
    @(negedge clk);
    tests_run++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || flag_e !== 1'b0 || flag_gt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset outputs: got dreq=%0b ireq=%0b e=%0b gt=%0b, expected all 0", dmem_req, imem_req, flag_e, flag_gt);
    end
`ifdef SEQ_PERF_CNT_EN
    tests_run++;
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset counters: got %0d/%0d, expected 0/0", cyc_cnt, ret_cnt);
    end
`endif
    m_e = 1'b0; m_gt = 1'b0; retired = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset fetch: got ireq=%0b dreq=%0b, expected 1/0", imem_req, dmem_req);
    end
    run_instr("add_after_reset", OP_ADD, F_WB, 0, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_cmp_branch();
    test_memory();
    test_muldiv();
    test_call_ret();
    test_back_to_back();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
